uart_cmd_assembler: RTL and testbench
=====================================

Name: uart_cmd_assembler

Overview:
- Sits directly downstream of the UART receiver.
- Consumes the receiver's byte stream (`rx_data`/`rdy`) and acknowledges each byte with `clr_rdy`.
- Packs byte pairs, high byte first, into a 16-bit command for the command-processing logic.
- An inter-byte timeout resynchronises framing after a lost byte; an overrun flag reports commands dropped because the consumer was not ready.

Parameters:
- `TIMEOUT_CYCLES`, default 65536: clk cycles allowed between high-byte acceptance and low-byte arrival. The default exceeds one 19200-baud byte time at 50 MHz (~26040 cycles) with margin. Legal range 2..2^20.
- `CNT_W`, default `$clog2(TIMEOUT_CYCLES)`: timeout counter width. Derived; not overridden.

Ports:
- `clk` input 1: system clock, all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `rx_data` input 8: received byte from the UART receiver, valid while `rx_rdy`=1.
- `rx_rdy` input 1: receiver byte-ready flag (level, held until cleared).
- `rx_clr_rdy` output 1: acknowledge to the receiver, clears its `rdy`.
- `cmd` output 16: assembled command, {high byte, low byte}.
- `cmd_rdy` output 1: command valid; level, held until `clr_cmd_rdy`.
- `clr_cmd_rdy` input 1: consumer acknowledge.
- `overrun` output 1: sticky; a command completed while `cmd_rdy` was still set.
- `frame_err` output 1: one-cycle pulse on inter-byte timeout.

Behaviour:
- Reset (sync, `rst`=1 at posedge):
  - state=WAIT_HI; `cmd`=16'h0000; high-byte holding reg=8'h00; `cmd_rdy`=0; `overrun`=0; timeout counter=0.
  - `frame_err`=0 and `rx_clr_rdy`=0 while `rst`=1.
  - Reset mid-command discards the partial byte.
- `rx_clr_rdy` is combinational: `rx_clr_rdy` = `rx_rdy` & ~`rst`.
  - Every presented byte is consumed in the same cycle; no byte is ever seen twice. The receiver drops `rdy` the following cycle.
- State WAIT_HI:
  - On `rx_rdy`: latch `rx_data` into the high reg, clear the counter, go to WAIT_LO.
- State WAIT_LO:
  - On `rx_rdy`: `cmd` <= {high reg, `rx_data`}; `cmd_rdy` <= 1; go to WAIT_HI. `cmd` updates even if `cmd_rdy` was already 1.
  - Else, counter increments each cycle. When counter == `TIMEOUT_CYCLES`-1: `frame_err` pulses for 1 cycle (registered, asserted the cycle after the transition), the high byte is discarded, go to WAIT_HI.
  - If `rx_rdy` arrives in the same cycle the counter hits the limit, the byte wins: the command completes and there is no `frame_err`.
- Latency: `cmd`/`cmd_rdy` valid on the clk edge after the cycle in which the low byte's `rx_rdy` is sampled (1 cycle).
- `cmd_rdy`:
  - Cleared by `clr_cmd_rdy`.
  - Completion and `clr_cmd_rdy` in the same cycle: `cmd_rdy` stays 1 (set wins) and there is no overrun.
- `overrun`:
  - Set on completion when `cmd_rdy`=1 and `clr_cmd_rdy`=0.
  - Cleared only by `rst`.
- The default state case returns to WAIT_HI.

Decomposition:
- Shared package `uart_pkg`: `typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t`; constant `CMD_W`=16; constant `BYTE_W`=8.
- No sub-module required. The timeout counter is inline; a generic `timeout_cnt` module is optional but not needed.

Test Plan:
1. Reset, then bytes 8'hA5 and 8'h3C, 500 cycles apart -> `cmd`=16'hA53C with `cmd_rdy`=1 one cycle after the second `rx_rdy`; `rx_clr_rdy` high exactly one cycle per byte; `overrun`=0, `frame_err`=0.
2. `TIMEOUT_CYCLES`=100: byte 8'h11, then silence 150 cycles, then 8'h22, 8'h33 -> one `frame_err` pulse ~100 cycles after 8'h11; final `cmd`=16'h2233.
3. Two commands 16'h1234 then 16'h5678 with no `clr_cmd_rdy` -> `cmd`=16'h5678, `cmd_rdy`=1, `overrun`=1 and remaining 1 after later `clr_cmd_rdy`.
4. Low byte 8'hEF (high 8'hBE) completes in the same cycle `clr_cmd_rdy`=1 -> `cmd`=16'hBEEF, `cmd_rdy`=1, `overrun`=0.
5. `rst` asserted one cycle while in WAIT_LO after high 8'hFF, then bytes 8'h01, 8'h02 -> `cmd`=16'h0102; all outputs at reset values during `rst`.
6. `TIMEOUT_CYCLES`=100: low byte `rx_rdy` arrives exactly on the counter limit cycle -> command completes, no `frame_err`.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose: shared types and widths for the UART command assembler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int CMD_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } asm_state_t;

endpackage : uart_pkg

// File: rtl/uart_cmd_assembler.sv
// Purpose: packs pairs of received UART bytes (high first) into 16-bit commands.
// Latency: cmd/cmd_rdy valid one clk after the low byte's rx_rdy is sampled.
// Backpressure: none toward the receiver (every byte acked the same cycle);
//               an unconsumed command is overwritten and flagged by sticky overrun.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rx_data, rx_rdy     - byte and level ready flag from the UART receiver
//   rx_clr_rdy          - combinational acknowledge clearing the receiver's flag
//   cmd, cmd_rdy        - assembled command and its held valid level
//   clr_cmd_rdy         - consumer acknowledge for cmd_rdy
//   overrun             - sticky: a command completed while cmd_rdy was still set
//   frame_err           - one-cycle pulse when the low byte never arrived in time
module uart_cmd_assembler
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_rdy,
  output logic              rx_clr_rdy,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy,
  output logic              overrun,
  output logic              frame_err
);

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  asm_state_t        state_q, state_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              ovr_q, ovr_d;
  logic              ferr_q, ferr_d;
  logic              complete;

  // The byte is always consumed in the cycle it is presented, so the receiver
  // drops rdy next cycle and no byte is ever seen twice.
  assign rx_clr_rdy = rx_rdy & ~rst;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    ferr_d   = 1'b0;
    complete = 1'b0;
    case (state_q)
      WAIT_HI: begin
        if (rx_rdy) begin
          hi_d    = rx_data;
          cnt_d   = '0;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // A byte arriving on the limit cycle beats the timeout.
        if (rx_rdy) begin
          cmd_d    = {hi_q, rx_data};
          complete = 1'b1;
          state_d  = WAIT_HI;
        end else if (cnt_q == CNT_LIM) begin
          ferr_d  = 1'b1;
          hi_d    = '0;
          state_d = WAIT_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = WAIT_HI;
    endcase

    // Completion wins over a same-cycle acknowledge; that case is not an overrun.
    cmd_rdy_d = complete | (cmd_rdy_q & ~clr_cmd_rdy);
    ovr_d     = ovr_q | (complete & cmd_rdy_q & ~clr_cmd_rdy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_HI;
      hi_q      <= '0;
      cmd_q     <= '0;
      cnt_q     <= '0;
      cmd_rdy_q <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      cmd_rdy_q <= cmd_rdy_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign overrun   = ovr_q;
  // Masked so a pulse registered just before reset never shows while rst is high.
  assign frame_err = ferr_q & ~rst;

endmodule : uart_cmd_assembler

// File: tb/tb_uart_cmd_assembler.sv
module tb_uart_cmd_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_cmd_rdy;

  logic        a_clr, b_clr;
  logic [15:0] a_cmd, b_cmd;
  logic        a_rdy, b_rdy, a_ovr, b_ovr, a_ferr, b_ferr;

  int checks = 0;
  int errors = 0;
  int a_clr_cnt = 0;
  int a_ferr_cnt = 0;
  int b_ferr_cnt = 0;

  always #5 clk = ~clk;

  // Default timeout instance and a short-timeout instance share the stimulus.
  uart_cmd_assembler dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .rx_clr_rdy(a_clr), .cmd(a_cmd), .cmd_rdy(a_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .overrun(a_ovr), .frame_err(a_ferr)
  );

  uart_cmd_assembler #(.TIMEOUT_CYCLES(100)) dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .rx_clr_rdy(b_clr), .cmd(b_cmd), .cmd_rdy(b_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .overrun(b_ovr), .frame_err(b_ferr)
  );

  always @(negedge clk) begin
    a_clr_cnt  <= a_clr_cnt + int'(a_clr);
    a_ferr_cnt <= a_ferr_cnt + int'(a_ferr);
    b_ferr_cnt <= b_ferr_cnt + int'(b_ferr);
  end

  typedef struct {
    bit          do_rst;
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          gap;
    bit          clr_with_lo;
    logic [15:0] exp_cmd;
    logic        exp_rdy;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One-cycle rdy pulse models the receiver dropping rdy after the ack.
  task automatic send(input logic [7:0] b, input bit clr);
    rx_data     = b;
    rx_rdy      = 1'b1;
    clr_cmd_rdy = clr;
    tick();
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int c0, f0, g0;

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 500, 1'b0, 16'hA53C, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 8'h12, 8'h34, 3,   1'b0, 16'h1234, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h56, 8'h78, 3,   1'b0, 16'h5678, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 8'hCA, 8'hFE, 1,   1'b0, 16'hCAFE, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'hBE, 8'hEF, 0,   1'b1, 16'hBEEF, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'hFF, 8'h00, 2,   1'b0, 16'hFF00, 1'b1, 1'b1};

    idle(2);
    chk("reset_cmd", 32'(a_cmd), 32'h0);
    chk("reset_cmd_rdy", 32'(a_rdy), 32'h0);
    chk("reset_overrun", 32'(a_ovr), 32'h0);
    chk("reset_frame_err", 32'(a_ferr), 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_rst) do_reset();
      c0 = a_clr_cnt; f0 = a_ferr_cnt;
      send(vecs[i].hi, 1'b0);
      chk($sformatf("v%0d_no_early_rdy", i), 32'(a_rdy), (vecs[i].do_rst ? 32'h0 : 32'h1));
      idle(vecs[i].gap);
      send(vecs[i].lo, vecs[i].clr_with_lo);
      chk($sformatf("v%0d_cmd", i), 32'(a_cmd), 32'(vecs[i].exp_cmd));
      chk($sformatf("v%0d_cmd_rdy", i), 32'(a_rdy), 32'(vecs[i].exp_rdy));
      chk($sformatf("v%0d_overrun", i), 32'(a_ovr), 32'(vecs[i].exp_ovr));
      tick();
      chk($sformatf("v%0d_clr_pulses", i), 32'(a_clr_cnt - c0), 32'd2);
      chk($sformatf("v%0d_no_frame_err", i), 32'(a_ferr_cnt - f0), 32'd0);
    end

    // Overrun is sticky across a consumer acknowledge.
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("ack_clears_cmd_rdy", 32'(a_rdy), 32'h0);
    chk("overrun_sticky", 32'(a_ovr), 32'h1);
    idle(3);
    chk("overrun_still_sticky", 32'(a_ovr), 32'h1);

    // Reset in WAIT_LO discards the partial high byte; ack suppressed during rst.
    send(8'hFF, 1'b0);
    rst = 1'b1; rx_data = 8'h77; rx_rdy = 1'b1;
    #1;
    chk("rst_blocks_clr", 32'(a_clr), 32'h0);
    tick();
    chk("rst_cmd", 32'(a_cmd), 32'h0);
    chk("rst_cmd_rdy", 32'(a_rdy), 32'h0);
    chk("rst_overrun", 32'(a_ovr), 32'h0);
    chk("rst_frame_err", 32'(a_ferr), 32'h0);
    chk("rst_clr_still_low", 32'(a_clr), 32'h0);
    rst = 1'b0; rx_rdy = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    chk("after_rst_cmd", 32'(a_cmd), 32'h0102);
    chk("after_rst_rdy", 32'(a_rdy), 32'h1);

    // Short-timeout instance: high byte then silence -> single frame_err pulse.
    do_reset();
    g0 = b_ferr_cnt;
    send(8'h11, 1'b0);
    idle(99);
    chk("to_not_yet", 32'(b_ferr), 32'h0);
    tick();
    chk("to_pulse", 32'(b_ferr), 32'h1);
    tick();
    chk("to_pulse_one_cycle", 32'(b_ferr), 32'h0);
    idle(48);
    chk("to_pulse_count", 32'(b_ferr_cnt - g0), 32'd1);
    chk("to_no_cmd", 32'(b_rdy), 32'h0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("to_resync_cmd", 32'(b_cmd), 32'h2233);
    chk("to_resync_rdy", 32'(b_rdy), 32'h1);

    // Low byte on exactly the limit cycle completes the command.
    do_reset();
    g0 = b_ferr_cnt;
    send(8'hAB, 1'b0);
    idle(99);
    send(8'hCD, 1'b0);
    chk("limit_cmd", 32'(b_cmd), 32'hABCD);
    chk("limit_rdy", 32'(b_rdy), 32'h1);
    chk("limit_no_ferr", 32'(b_ferr), 32'h0);
    idle(3);
    chk("limit_no_ferr_count", 32'(b_ferr_cnt - g0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_cmd_assembler
